// File: rtl/sb_edge_bottom_param.sv
// Bottom-edge switch block: routes W-track channels and NPAD pad outputs onto the
// channel tracks from a double-buffered configuration chain (shift into chain, commit into active).
module sb_edge_bottom_param #(
  parameter int W    = 4,
  parameter int NPAD = 14
) (
  input  logic            prog_clk,
  input  logic            prog_reset_n,
  input  logic [W-1:0]    chany_top_in,
  input  logic [W-1:0]    chanx_right_in,
  input  logic [W-1:0]    chanx_left_in,
  input  logic [NPAD-1:0] pad_in,
  input  logic            ccff_head,
  input  logic            cfg_shift_en,
  input  logic            cfg_commit,
  output logic [W-1:0]    chany_top_out,
  output logic [W-1:0]    chanx_right_out,
  output logic [W-1:0]    chanx_left_out,
  output logic            ccff_tail,
  output logic            cfg_done,
  output logic            cfg_err
);

  localparam int LSW = $clog2(1 + (NPAD + W - 1) / W);
  localparam int N   = W + W * LSW;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  logic [N-1:0]  chain_q, chain_d;
  logic [N-1:0]  active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  // Next-state for the configuration chain, active copy, bit counter and error flag.
  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (cfg_shift_en) begin
      chain_d = {chain_q[N-2:0], ccff_head};
      if (cnt_q != N_C) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // A commit colliding with a shift is refused; the shift still happens.
      if (cfg_commit) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (cfg_commit) begin
      if (cnt_q == N_C) begin
        active_d = chain_q;
        cnt_d    = {CW{1'b0}};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      chain_d = chain_q;
    end
    done_d = (cnt_d == N_C);
  end

  // Configuration state registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      chain_q  <= {N{1'b0}};
      active_q <= {N{1'b0}};
      cnt_q    <= {CW{1'b0}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Combinational routing muxes driven only by the committed configuration.
  always_comb begin
    logic [LSW-1:0] sel;
    int             idx;
    chanx_right_out = {W{1'b0}};
    chany_top_out   = {W{1'b0}};
    chanx_left_out  = {W{1'b0}};
    sel             = {LSW{1'b0}};
    idx             = 0;
    for (int i = 0; i < W; i++) begin
      chanx_right_out[(i + 1) % W] = chany_top_in[i];
      if (active_q[N-1-i]) begin
        chany_top_out[i] = chanx_left_in[(W - i) % W];
      end else begin
        chany_top_out[i] = chanx_right_in[(i + 1) % W];
      end
    end
    for (int j = 0; j < W; j++) begin
      for (int k = 0; k < LSW; k++) begin
        sel[LSW-1-k] = active_q[N-1-W-j*LSW-k];
      end
      if (sel == {LSW{1'b0}}) begin
        chanx_left_out[j] = chany_top_in[(W - j) % W];
      end else begin
        // Selects that point past the last pad read as constant zero.
        idx = j + (int'(sel) - 1) * W;
        if (idx < NPAD) begin
          chanx_left_out[j] = pad_in[idx];
        end else begin
          chanx_left_out[j] = 1'b0;
        end
      end
    end
  end

  assign ccff_tail = chain_q[N-1];
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sb_edge_bottom_param.sv
// Directed bench for sb_edge_bottom_param: expectations are queued when stimulus
// is applied and popped against DUT outputs once they are valid.
module tb_sb_edge_bottom_param;

  logic        prog_clk;
  logic        prog_reset_n;
  logic [3:0]  chany_top_in, chanx_right_in, chanx_left_in;
  logic [13:0] pad_in;
  logic        ccff_head, cfg_shift_en, cfg_commit;
  logic [3:0]  chany_top_out, chanx_right_out, chanx_left_out;
  logic        ccff_tail, cfg_done, cfg_err;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  sb_edge_bottom_param #(.W(4), .NPAD(14)) dut (
    .prog_clk       (prog_clk),
    .prog_reset_n   (prog_reset_n),
    .chany_top_in   (chany_top_in),
    .chanx_right_in (chanx_right_in),
    .chanx_left_in  (chanx_left_in),
    .pad_in         (pad_in),
    .ccff_head      (ccff_head),
    .cfg_shift_en   (cfg_shift_en),
    .cfg_commit     (cfg_commit),
    .chany_top_out  (chany_top_out),
    .chanx_right_out(chanx_right_out),
    .chanx_left_out (chanx_left_out),
    .ccff_tail      (ccff_tail),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [15:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sbq.push_back(item);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t item;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      item = sbq.pop_front();
      assert (obs === item.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic shift1(input logic b);
    ccff_head    = b;
    cfg_shift_en = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_shift_en = 1'b0;
    ccff_head    = 1'b0;
  endtask

  task automatic commit1();
    cfg_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic push_route(input string tag, input logic [3:0] top_e, input logic [3:0] left_e);
    push_exp({tag, "_top"}, {12'h000, top_e});
    push_exp({tag, "_left"}, {12'h000, left_e});
  endtask

  task automatic pop_route();
    pop_chk({12'h000, chany_top_out});
    pop_chk({12'h000, chanx_left_out});
  endtask

  logic [15:0] prog_bits;
  logic [15:0] pat16;
  logic [31:0] pat32;

  initial begin
    prog_reset_n   = 1'b0;
    chany_top_in   = 4'b0000;
    chanx_right_in = 4'b0000;
    chanx_left_in  = 4'b0000;
    pad_in         = 14'h0000;
    ccff_head      = 1'b0;
    cfg_shift_en   = 1'b0;
    cfg_commit     = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset_n = 1'b1;

    // Mid-stream activity that sets the sticky error, then an asynchronous reset.
    shift1(1'b1);
    shift1(1'b1);
    shift1(1'b0);
    push_exp("early_err_pre_reset", 16'h0001);
    commit1();
    pop_chk({15'h0000, cfg_err});
    chany_top_in   = 4'b1010;
    chanx_right_in = 4'b0110;
    chanx_left_in  = 4'b0010;
    push_exp("rst_tail", 16'h0000);
    push_exp("rst_done", 16'h0000);
    push_exp("rst_err", 16'h0000);
    push_exp("rst_right", 16'h0005);
    push_route("rst", 4'b0011, 4'b1010);
    #2;
    prog_reset_n = 1'b0;
    #1;
    pop_chk({15'h0000, ccff_tail});
    pop_chk({15'h0000, cfg_done});
    pop_chk({15'h0000, cfg_err});
    pop_chk({12'h000, chanx_right_out});
    pop_route();
    @(posedge prog_clk);
    #1;
    prog_reset_n = 1'b1;

    // Full program: top0=1, top1..3=0, left0=1, left1=4, left2=4, left3=0.
    prog_bits = 16'b1000_001_100_100_000;
    for (int i = 0; i < 16; i++) begin
      push_exp("prog_done", (i == 15) ? 16'h0001 : 16'h0000);
      shift1(prog_bits[15-i]);
      pop_chk({15'h0000, cfg_done});
    end
    push_exp("prog_tail", 16'h0001);
    push_route("pre_commit", 4'b0011, 4'b1010);
    pop_chk({15'h0000, ccff_tail});
    pop_route();
    push_exp("commit_done", 16'h0000);
    push_exp("commit_err", 16'h0000);
    commit1();
    pop_chk({15'h0000, cfg_done});
    pop_chk({15'h0000, cfg_err});
    pad_in = 14'h2001;
    push_route("post_commit", 4'b0010, 4'b1011);
    #1;
    pop_route();
    chanx_left_in = 4'b0001;
    push_route("left_in_sel", 4'b0011, 4'b1011);
    #1;
    pop_route();
    pad_in = 14'h2000;
    push_route("pad13_only", 4'b0011, 4'b1010);
    #1;
    pop_route();
    pad_in = 14'h3fff;
    push_route("pad_all_oor", 4'b0011, 4'b1011);
    #1;
    pop_route();
    pad_in        = 14'h2001;
    chanx_left_in = 4'b0010;
    #1;

    // Shifting with live routing, with an early commit after the fifth bit.
    shift1(1'b1); push_route("glitch1", 4'b0010, 4'b1011); pop_route();
    shift1(1'b1); push_route("glitch2", 4'b0010, 4'b1011); pop_route();
    shift1(1'b0); push_route("glitch3", 4'b0010, 4'b1011); pop_route();
    shift1(1'b1); push_route("glitch4", 4'b0010, 4'b1011); pop_route();
    shift1(1'b0); push_route("glitch5", 4'b0010, 4'b1011); pop_route();
    push_exp("early_err", 16'h0001);
    push_exp("early_done", 16'h0000);
    push_route("early_commit", 4'b0010, 4'b1011);
    commit1();
    pop_chk({15'h0000, cfg_err});
    pop_chk({15'h0000, cfg_done});
    pop_route();
    shift1(1'b0); push_route("glitch6", 4'b0010, 4'b1011); pop_route();
    shift1(1'b1); push_route("glitch7", 4'b0010, 4'b1011); pop_route();
    push_exp("err_sticky", 16'h0001);
    repeat (3) @(posedge prog_clk);
    #1;
    pop_chk({15'h0000, cfg_err});
    push_exp("reset_clears_err", 16'h0000);
    push_route("reset_routing", 4'b0011, 4'b1010);
    prog_reset_n = 1'b0;
    #1;
    pop_chk({15'h0000, cfg_err});
    pop_route();
    @(posedge prog_clk);
    #1;
    prog_reset_n = 1'b1;

    // Commit colliding with a shift when the chain is full, then an accepted commit.
    pat16 = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      shift1(pat16[15-i]);
    end
    push_exp("full_done", 16'h0001);
    push_exp("full_tail", 16'h0001);
    pop_chk({15'h0000, cfg_done});
    pop_chk({15'h0000, ccff_tail});
    push_exp("simul_err", 16'h0001);
    push_exp("simul_done", 16'h0001);
    push_exp("simul_tail", 16'h0000);
    push_route("simul_routing", 4'b0011, 4'b1010);
    cfg_commit = 1'b1;
    shift1(1'b1);
    cfg_commit = 1'b0;
    pop_chk({15'h0000, cfg_err});
    pop_chk({15'h0000, cfg_done});
    pop_chk({15'h0000, ccff_tail});
    pop_route();
    push_exp("over_commit_done", 16'h0000);
    push_exp("over_commit_err", 16'h0001);
    push_exp("over_commit_top", 16'h0001);
    commit1();
    pop_chk({15'h0000, cfg_done});
    pop_chk({15'h0000, cfg_err});
    pop_chk({12'h000, chany_top_out});

    // Chain pass-through: tail replays the stream 16 edges later.
    prog_reset_n = 1'b0;
    #1;
    prog_reset_n = 1'b1;
    pat32 = 32'hDEADBEEF;
    for (int k = 1; k <= 32; k++) begin
      push_exp("pass_tail", (k >= 16) ? {15'h0000, pat32[32-(k-15)]} : 16'h0000);
      push_exp("pass_done", (k >= 16) ? 16'h0001 : 16'h0000);
      shift1(pat32[32-k]);
      pop_chk({15'h0000, ccff_tail});
      pop_chk({15'h0000, cfg_done});
    end

    if (sbq.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
